// File: rtl/sm_fifo.sv
// sm_fifo: TX/RX FIFO pair serving one PIO state machine.
// The host fills TX and the machine pulls from it. The machine pushes into RX
// and the host drains it.
// The two storage halves can be joined into one FIFO of twice the depth.
// All status outputs are derived from registered state only.
module sm_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clear,
    input  logic                       i_join_tx,
    input  logic                       i_join_rx,
    input  logic                       i_tick,
    input  logic                       i_pull,
    output logic [WIDTH-1:0]           o_din,
    output logic                       o_empty,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_dout,
    output logic                       o_full,
    input  logic                       i_tx_wr,
    input  logic [WIDTH-1:0]           i_tx_wdata,
    output logic                       o_tx_full,
    output logic [$clog2(2*DEPTH):0]   o_tx_level,
    input  logic                       i_rx_rd,
    output logic [WIDTH-1:0]           o_rx_rdata,
    output logic                       o_rx_empty,
    output logic [$clog2(2*DEPTH):0]   o_rx_level,
    input  logic                       i_flags_clr,
    output logic                       o_tx_over,
    output logic                       o_rx_under,
    output logic                       o_tx_stall,
    output logic                       o_rx_stall
);

    localparam int PW = $clog2(2*DEPTH);
    localparam int LW = PW + 1;
    localparam int NE = 2*DEPTH;

    // TX owns the lower half. RX owns the upper half unless RX is joined.
    logic [WIDTH-1:0] r_mem [0:NE-1];
    logic [PW-1:0]    r_tx_rptr, r_tx_wptr, r_rx_rptr, r_rx_wptr;
    logic [LW-1:0]    r_tx_level, r_rx_level;
    logic             r_join_tx, r_join_rx;
    logic             r_tx_over, r_rx_under, r_tx_stall, r_rx_stall;

    logic [LW-1:0]    w_tx_cap, w_rx_cap;
    logic [PW-1:0]    w_rx_base, w_tx_last, w_rx_last;
    logic [PW-1:0]    w_rx_raddr, w_rx_waddr;
    logic             w_flush;
    logic             w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic             w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic             w_tx_over_ev, w_rx_under_ev, w_tx_stall_ev, w_rx_stall_ev;

    // Advance a pointer, wrapping after the last valid slot of the FIFO.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p, input logic [PW-1:0] last);
        return (p == last) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Capacity and RX base come from the registered join copy. A join change
    // flushes both FIFOs in the same cycle, so the copy is current for every
    // cycle in which strobes are honoured. Both joins set counts as neither.
    always_comb begin
        w_tx_cap  = LW'(DEPTH);
        w_rx_cap  = LW'(DEPTH);
        w_rx_base = PW'(DEPTH);
        if (r_join_tx && !r_join_rx) begin
            w_tx_cap = LW'(NE);
            w_rx_cap = {LW{1'b0}};
        end else if (r_join_rx && !r_join_tx) begin
            w_tx_cap  = {LW{1'b0}};
            w_rx_cap  = LW'(NE);
            w_rx_base = {PW{1'b0}};
        end else begin
            w_tx_cap = LW'(DEPTH);
        end
    end

    // Status decode and accept/refuse decisions. A cap-0 FIFO reads as both full and empty.
    always_comb begin
        w_tx_last     = PW'(w_tx_cap - LW'(1));
        w_rx_last     = PW'(w_rx_cap - LW'(1));
        w_rx_raddr    = w_rx_base + r_rx_rptr;
        w_rx_waddr    = w_rx_base + r_rx_wptr;
        w_flush       = i_clear | (i_join_tx != r_join_tx) | (i_join_rx != r_join_rx);
        w_tx_empty    = (r_tx_level == {LW{1'b0}});
        w_tx_full     = (r_tx_level == w_tx_cap);
        w_rx_empty    = (r_rx_level == {LW{1'b0}});
        w_rx_full     = (r_rx_level == w_rx_cap);
        w_tx_pop      = i_pull & i_tick & ~w_tx_empty & ~w_flush;
        w_tx_push     = i_tx_wr & ~w_tx_full & ~w_flush;
        w_rx_push     = i_push & i_tick & ~w_rx_full & ~w_flush;
        w_rx_pop      = i_rx_rd & ~w_rx_empty & ~w_flush;
        w_tx_stall_ev = i_pull & i_tick & w_tx_empty & ~w_flush;
        w_tx_over_ev  = i_tx_wr & w_tx_full & ~w_flush;
        w_rx_stall_ev = i_push & i_tick & w_rx_full & ~w_flush;
        w_rx_under_ev = i_rx_rd & w_rx_empty & ~w_flush;
    end

    // Storage writes. Contents need no reset because the levels gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_tx_push) begin
            r_mem[r_tx_wptr] <= i_tx_wdata;
        end
        if (w_rx_push) begin
            r_mem[w_rx_waddr] <= i_dout;
        end
    end

    // Registered copy of the join configuration, used to detect a change.
    always_ff @(posedge i_clk) begin
        r_join_tx <= i_join_tx;
        r_join_rx <= i_join_rx;
    end

    // Pointer and level bookkeeping for both FIFOs. Reset and flush both empty them.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_flush) begin
            r_tx_rptr  <= {PW{1'b0}};
            r_tx_wptr  <= {PW{1'b0}};
            r_rx_rptr  <= {PW{1'b0}};
            r_rx_wptr  <= {PW{1'b0}};
            r_tx_level <= {LW{1'b0}};
            r_rx_level <= {LW{1'b0}};
        end else begin
            if (w_tx_push) r_tx_wptr <= f_next(r_tx_wptr, w_tx_last);
            if (w_tx_pop)  r_tx_rptr <= f_next(r_tx_rptr, w_tx_last);
            if (w_rx_push) r_rx_wptr <= f_next(r_rx_wptr, w_rx_last);
            if (w_rx_pop)  r_rx_rptr <= f_next(r_rx_rptr, w_rx_last);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_level <= r_tx_level + LW'(1);
                2'b01:   r_tx_level <= r_tx_level - LW'(1);
                default: r_tx_level <= r_tx_level;
            endcase
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_level <= r_rx_level + LW'(1);
                2'b01:   r_rx_level <= r_rx_level - LW'(1);
                default: r_rx_level <= r_rx_level;
            endcase
        end
    end

    // Sticky error flags. A same-cycle event beats flags_clr, and a flush leaves the flags alone.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_over  <= 1'b0;
            r_rx_under <= 1'b0;
            r_tx_stall <= 1'b0;
            r_rx_stall <= 1'b0;
        end else begin
            r_tx_over  <= w_tx_over_ev  | (r_tx_over  & ~i_flags_clr);
            r_rx_under <= w_rx_under_ev | (r_rx_under & ~i_flags_clr);
            r_tx_stall <= w_tx_stall_ev | (r_tx_stall & ~i_flags_clr);
            r_rx_stall <= w_rx_stall_ev | (r_rx_stall & ~i_flags_clr);
        end
    end

    assign o_din      = w_tx_empty ? {WIDTH{1'b0}} : r_mem[r_tx_rptr];
    assign o_rx_rdata = w_rx_empty ? {WIDTH{1'b0}} : r_mem[w_rx_raddr];
    assign o_empty    = w_tx_empty;
    assign o_tx_full  = w_tx_full;
    assign o_full     = w_rx_full;
    assign o_rx_empty = w_rx_empty;
    assign o_tx_level = r_tx_level;
    assign o_rx_level = r_rx_level;
    assign o_tx_over  = r_tx_over;
    assign o_rx_under = r_rx_under;
    assign o_tx_stall = r_tx_stall;
    assign o_rx_stall = r_rx_stall;

endmodule

// File: tb/tb_sm_fifo.sv
// Testbench for sm_fifo. It applies a table of directed vectors, then
// hand-written corner sequences, then random traffic. Every cycle is checked
// against a queue-based reference model.
module tb_sm_fifo;
    localparam int D  = 4;
    localparam int W  = 32;
    localparam int LW = $clog2(2*D) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, clear, join_tx, join_rx, tick, pull, push, tx_wr, rx_rd, flags_clr;
    logic [W-1:0] dout, tx_wdata;
    logic [W-1:0] din, rx_rdata;
    logic empty, full, tx_full, rx_empty, tx_over, rx_under, tx_stall, rx_stall;
    logic [LW-1:0] tx_level, rx_level;

    sm_fifo #(.DEPTH(D), .WIDTH(W)) dut (
        .i_clk(clk), .i_reset(reset), .i_clear(clear),
        .i_join_tx(join_tx), .i_join_rx(join_rx),
        .i_tick(tick), .i_pull(pull), .o_din(din), .o_empty(empty),
        .i_push(push), .i_dout(dout), .o_full(full),
        .i_tx_wr(tx_wr), .i_tx_wdata(tx_wdata), .o_tx_full(tx_full), .o_tx_level(tx_level),
        .i_rx_rd(rx_rd), .o_rx_rdata(rx_rdata), .o_rx_empty(rx_empty), .o_rx_level(rx_level),
        .i_flags_clr(flags_clr), .o_tx_over(tx_over), .o_rx_under(rx_under),
        .o_tx_stall(tx_stall), .o_rx_stall(rx_stall)
    );

    int total = 0;
    int bad   = 0;
    string phase = "init";

    // Reference model: plain queues plus flag bits and the previous join inputs.
    logic [W-1:0] mtx[$];
    logic [W-1:0] mrx[$];
    bit f_over, f_under, f_tst, f_rst;
    bit pj_tx, pj_rx;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int cap_of(bit jt, bit jr, bit is_tx);
        if (jt && !jr) return is_tx ? 2*D : 0;
        if (jr && !jt) return is_tx ? 0 : 2*D;
        return D;
    endfunction

    task automatic model_step();
        int ts, rs, ctx, crx;
        bit tpop, tpush, rpop, rpush, fl;
        tpop = 0; tpush = 0; rpop = 0; rpush = 0;
        if (reset) begin
            mtx.delete(); mrx.delete();
            f_over = 0; f_under = 0; f_tst = 0; f_rst = 0;
            pj_tx = join_tx; pj_rx = join_rx;
            return;
        end
        fl  = clear || (join_tx != pj_tx) || (join_rx != pj_rx);
        ctx = cap_of(join_tx, join_rx, 1);
        crx = cap_of(join_tx, join_rx, 0);
        ts  = mtx.size();
        rs  = mrx.size();
        if (flags_clr) begin
            f_over = 0; f_under = 0; f_tst = 0; f_rst = 0;
        end
        if (fl) begin
            mtx.delete(); mrx.delete();
        end else begin
            if (tick && pull) begin if (ts > 0) tpop = 1; else f_tst = 1; end
            if (tx_wr)        begin if (ts < ctx) tpush = 1; else f_over = 1; end
            if (tick && push) begin if (rs < crx) rpush = 1; else f_rst = 1; end
            if (rx_rd)        begin if (rs > 0) rpop = 1; else f_under = 1; end
            if (tpop)  void'(mtx.pop_front());
            if (tpush) mtx.push_back(tx_wdata);
            if (rpop)  void'(mrx.pop_front());
            if (rpush) mrx.push_back(dout);
        end
        pj_tx = join_tx; pj_rx = join_rx;
    endtask

    task automatic cmp_all();
        int ctx, crx;
        ctx = cap_of(pj_tx, pj_rx, 1);
        crx = cap_of(pj_tx, pj_rx, 0);
        chk({phase, " din"},      din,      (mtx.size() > 0) ? mtx[0] : 32'h0);
        chk({phase, " empty"},    {31'h0, empty},    {31'h0, mtx.size() == 0});
        chk({phase, " tx_full"},  {31'h0, tx_full},  {31'h0, mtx.size() == ctx});
        chk({phase, " tx_level"}, {{(W-LW){1'b0}}, tx_level}, mtx.size());
        chk({phase, " rx_rdata"}, rx_rdata, (mrx.size() > 0) ? mrx[0] : 32'h0);
        chk({phase, " rx_empty"}, {31'h0, rx_empty}, {31'h0, mrx.size() == 0});
        chk({phase, " full"},     {31'h0, full},     {31'h0, mrx.size() == crx});
        chk({phase, " rx_level"}, {{(W-LW){1'b0}}, rx_level}, mrx.size());
        chk({phase, " flags"}, {28'h0, tx_over, rx_under, tx_stall, rx_stall},
            {28'h0, f_over, f_under, f_tst, f_rst});
    endtask

    // One clock: update the model from the driven inputs, clock, then compare after the edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic idle();
        reset = 0; clear = 0; tick = 0; pull = 0; push = 0;
        tx_wr = 0; rx_rd = 0; flags_clr = 0; dout = '0; tx_wdata = '0;
    endtask

    typedef struct {
        bit           wr;
        logic [W-1:0] wd;
        bit           pl;
        bit           tk;
        bit           ps;
        logic [W-1:0] dv;
        bit           rd;
        int           e_txl;
        logic [W-1:0] e_din;
        int           e_rxl;
        logic [W-1:0] e_rd;
        logic [3:0]   e_flg; // {over, under, tx_stall, rx_stall}
    } vec_t;

    function automatic vec_t mkv(bit wr, logic [W-1:0] wd, bit pl, bit tk, bit ps, logic [W-1:0] dv,
                                 bit rd, int txl, logic [W-1:0] edin, int rxl, logic [W-1:0] erd,
                                 logic [3:0] flg);
        vec_t v;
        v.wr = wr; v.wd = wd; v.pl = pl; v.tk = tk; v.ps = ps; v.dv = dv; v.rd = rd;
        v.e_txl = txl; v.e_din = edin; v.e_rxl = rxl; v.e_rd = erd; v.e_flg = flg;
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        // Basic TX/RX traffic, overflow/underflow and stall vectors, starting right after reset.
        tbl[0]  = mkv(1, 32'hA1, 0, 0, 0, 32'h0, 0, 1, 32'hA1, 0, 32'h0, 4'b0000);
        tbl[1]  = mkv(1, 32'hA2, 0, 0, 0, 32'h0, 0, 2, 32'hA1, 0, 32'h0, 4'b0000);
        tbl[2]  = mkv(1, 32'hA3, 0, 0, 0, 32'h0, 0, 3, 32'hA1, 0, 32'h0, 4'b0000);
        tbl[3]  = mkv(1, 32'hA4, 0, 0, 0, 32'h0, 0, 4, 32'hA1, 0, 32'h0, 4'b0000);
        tbl[4]  = mkv(1, 32'hA5, 0, 0, 0, 32'h0, 0, 4, 32'hA1, 0, 32'h0, 4'b1000);
        tbl[5]  = mkv(0, 32'h0,  1, 1, 0, 32'h0, 0, 3, 32'hA2, 0, 32'h0, 4'b1000);
        tbl[6]  = mkv(0, 32'h0,  1, 1, 0, 32'h0, 0, 2, 32'hA3, 0, 32'h0, 4'b1000);
        tbl[7]  = mkv(0, 32'h0,  1, 1, 0, 32'h0, 0, 1, 32'hA4, 0, 32'h0, 4'b1000);
        tbl[8]  = mkv(0, 32'h0,  1, 1, 0, 32'h0, 0, 0, 32'h0,  0, 32'h0, 4'b1000);
        tbl[9]  = mkv(1, 32'h55, 0, 0, 0, 32'h0, 0, 1, 32'h55, 0, 32'h0, 4'b1000);
        tbl[10] = mkv(0, 32'h0,  1, 0, 0, 32'h0, 0, 1, 32'h55, 0, 32'h0, 4'b1000);
        tbl[11] = mkv(0, 32'h0,  1, 1, 0, 32'h0, 0, 0, 32'h0,  0, 32'h0, 4'b1000);
        tbl[12] = mkv(0, 32'h0,  1, 1, 0, 32'h0, 0, 0, 32'h0,  0, 32'h0, 4'b1010);
        tbl[13] = mkv(0, 32'h0,  0, 1, 1, 32'h10, 0, 0, 32'h0, 1, 32'h10, 4'b1010);
        tbl[14] = mkv(0, 32'h0,  0, 1, 1, 32'h11, 0, 0, 32'h0, 2, 32'h10, 4'b1010);
        tbl[15] = mkv(0, 32'h0,  0, 1, 1, 32'h12, 0, 0, 32'h0, 3, 32'h10, 4'b1010);
        tbl[16] = mkv(0, 32'h0,  0, 1, 1, 32'h13, 0, 0, 32'h0, 4, 32'h10, 4'b1010);
        tbl[17] = mkv(0, 32'h0,  0, 1, 1, 32'h14, 0, 0, 32'h0, 4, 32'h10, 4'b1011);
        tbl[18] = mkv(0, 32'h0,  0, 0, 0, 32'h0, 1, 0, 32'h0, 3, 32'h11, 4'b1011);
        tbl[19] = mkv(0, 32'h0,  0, 0, 0, 32'h0, 1, 0, 32'h0, 2, 32'h12, 4'b1011);
        tbl[20] = mkv(0, 32'h0,  0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h13, 4'b1011);
        tbl[21] = mkv(0, 32'h0,  0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0,  4'b1011);
        tbl[22] = mkv(0, 32'h0,  0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0,  4'b1111);
        tbl[23] = mkv(0, 32'h0,  0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0,  4'b1111);

        idle();
        join_tx = 0; join_rx = 0; reset = 1;
        phase = "reset";
        step(); step();
        chk("reset empty", {31'h0, empty}, 32'h1);
        chk("reset rx_empty", {31'h0, rx_empty}, 32'h1);
        chk("reset full", {31'h0, full}, 32'h0);
        chk("reset din", din, 32'h0);

        for (int i = 0; i < 24; i++) begin
            idle();
            tx_wr = tbl[i].wr; tx_wdata = tbl[i].wd; pull = tbl[i].pl; tick = tbl[i].tk;
            push = tbl[i].ps; dout = tbl[i].dv; rx_rd = tbl[i].rd;
            phase = $sformatf("vec%0d", i);
            step();
            chk($sformatf("vec%0d txl", i), {{(W-LW){1'b0}}, tx_level}, tbl[i].e_txl);
            chk($sformatf("vec%0d din", i), din, tbl[i].e_din);
            chk($sformatf("vec%0d rxl", i), {{(W-LW){1'b0}}, rx_level}, tbl[i].e_rxl);
            chk($sformatf("vec%0d rdata", i), rx_rdata, tbl[i].e_rd);
            chk($sformatf("vec%0d flags", i), {28'h0, tx_over, rx_under, tx_stall, rx_stall},
                {28'h0, tbl[i].e_flg});
        end

        // Simultaneous push and read on a full RX, then on a partially filled RX.
        phase = "rxsim";
        idle(); flags_clr = 1; step();
        for (int i = 0; i < 4; i++) begin
            idle(); tick = 1; push = 1; dout = 32'h20 + i; step();
        end
        idle(); tick = 1; push = 1; dout = 32'h99; rx_rd = 1; step();
        chk("rxsim full lvl", {{(W-LW){1'b0}}, rx_level}, 32'd3);
        chk("rxsim full head", rx_rdata, 32'h21);
        chk("rxsim full stall", {31'h0, rx_stall}, 32'h1);
        idle(); rx_rd = 1; step();
        idle(); tick = 1; push = 1; dout = 32'h77; rx_rd = 1; step();
        chk("rxsim mid lvl", {{(W-LW){1'b0}}, rx_level}, 32'd2);
        chk("rxsim mid head", rx_rdata, 32'h23);
        idle(); rx_rd = 1; step();
        chk("rxsim order", rx_rdata, 32'h77);
        idle(); rx_rd = 1; step();

        // TX joined: eight entries across both arrays; RX becomes a cap-0 FIFO.
        phase = "jtx";
        idle(); flags_clr = 1; join_tx = 1; step();
        chk("jtx rx full", {31'h0, full}, 32'h1);
        chk("jtx rx empty", {31'h0, rx_empty}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("jtx notfull%0d", i), {31'h0, tx_full}, 32'h0);
            idle(); tx_wr = 1; tx_wdata = i; step();
        end
        chk("jtx full8", {31'h0, tx_full}, 32'h1);
        chk("jtx lvl8", {{(W-LW){1'b0}}, tx_level}, 32'd8);
        idle(); tick = 1; push = 1; dout = 32'h5A; step();
        chk("jtx rx drop stall", {31'h0, rx_stall}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("jtx rd%0d", i), din, i);
            idle(); tick = 1; pull = 1; step();
        end
        chk("jtx drained", {31'h0, empty}, 32'h1);
        idle(); join_tx = 0; step();

        // clear together with tx_wr, join toggle flush, then reset mid-stream.
        phase = "flush";
        idle(); flags_clr = 1; step();
        for (int i = 0; i < 3; i++) begin
            idle(); tx_wr = 1; tx_wdata = 32'hC0 + i; step();
        end
        chk("clr lvl3", {{(W-LW){1'b0}}, tx_level}, 32'd3);
        idle(); clear = 1; tx_wr = 1; tx_wdata = 32'hCC; step();
        chk("clr lvl0", {{(W-LW){1'b0}}, tx_level}, 32'd0);
        chk("clr over kept", {31'h0, tx_over}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(); tx_wr = 1; tx_wdata = 32'hD0 + i; step();
        end
        idle(); clear = 1; tx_wr = 1; step();
        chk("clr full no over", {31'h0, tx_over}, 32'h0);
        chk("clr full lvl0", {{(W-LW){1'b0}}, tx_level}, 32'd0);
        idle(); tx_wr = 1; tx_wdata = 32'hE1; tick = 1; push = 1; dout = 32'hE2; step();
        idle(); join_rx = 1; tx_wr = 1; tx_wdata = 32'hE3; step();
        chk("jrx flush txl", {{(W-LW){1'b0}}, tx_level}, 32'd0);
        chk("jrx flush rxl", {{(W-LW){1'b0}}, rx_level}, 32'd0);
        chk("jrx tx cap0 full", {31'h0, tx_full}, 32'h1);
        idle(); join_rx = 0; step();
        for (int i = 0; i < 5; i++) begin
            idle(); tx_wr = 1; tx_wdata = 32'hF0 + i; tick = 1; push = 1; dout = 32'hB0 + i; step();
        end
        idle(); reset = 1; step();
        chk("rst din", din, 32'h0);
        chk("rst rdata", rx_rdata, 32'h0);
        chk("rst txl", {{(W-LW){1'b0}}, tx_level}, 32'd0);
        chk("rst rxl", {{(W-LW){1'b0}}, rx_level}, 32'd0);
        chk("rst flags", {28'h0, tx_over, rx_under, tx_stall, rx_stall}, 32'h0);
        chk("rst stat", {28'h0, empty, rx_empty, full, tx_full}, 32'hC);

        // Random traffic against the model.
        phase = "rand";
        for (int i = 0; i < 1500; i++) begin
            idle();
            reset     = ($urandom_range(0, 299) == 0);
            clear     = ($urandom_range(0, 59) == 0);
            flags_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 79) == 0) join_tx = ~join_tx;
            if ($urandom_range(0, 79) == 0) join_rx = ~join_rx;
            tick     = ($urandom_range(0, 3) != 0);
            pull     = $urandom_range(0, 1);
            push     = $urandom_range(0, 1);
            tx_wr    = $urandom_range(0, 1);
            rx_rd    = $urandom_range(0, 1);
            dout     = $urandom;
            tx_wdata = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
